// File: rtl/router_sa_credit_alloc.sv
// rtl/router_sa_credit_alloc.sv - switch-allocation stage with per-output round-robin and downstream credit tracking
//
// Each output port runs its own round-robin arbiter over the input ports that
// request it. A request is eligible only while the downstream VC it targets
// holds at least one credit. Grants are combinational (same-cycle) and drive the
// input-buffer pop strobes and the crossbar selects.
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   sa_req_v_i / _outport_i / _vc_id_i   per-input request, target outport, VC
//   inport_read_enable_sa_stage / inport_read_vc_id_sa_stage   per-input pop strobe and VC
//   xbar_v_o / xbar_sel_o        per-output valid and selected input index
//   tx_lcrd_v_i / tx_lcrd_id_i   per-output credit return and its VC
//   crd_err_o                    sticky: credit overflow or out-of-range outport
module router_sa_credit_alloc #(
    parameter int INPUT_PORT_NUM  = 5,
    parameter int OUTPUT_PORT_NUM = 5,
    parameter int VC_ID_NUM_MAX_W = 1,
    parameter int CRD_MAX         = 4,
    parameter int CRD_W           = 3,
    parameter int OP_W            = 3,
    parameter int IP_W            = 3
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic [INPUT_PORT_NUM-1:0]                   sa_req_v_i,
    input  logic [INPUT_PORT_NUM*OP_W-1:0]              sa_req_outport_i,
    input  logic [INPUT_PORT_NUM*VC_ID_NUM_MAX_W-1:0]   sa_req_vc_id_i,
    output logic [INPUT_PORT_NUM-1:0]                   inport_read_enable_sa_stage,
    output logic [INPUT_PORT_NUM*VC_ID_NUM_MAX_W-1:0]   inport_read_vc_id_sa_stage,
    output logic [OUTPUT_PORT_NUM-1:0]                  xbar_v_o,
    output logic [OUTPUT_PORT_NUM*IP_W-1:0]             xbar_sel_o,
    input  logic [OUTPUT_PORT_NUM-1:0]                  tx_lcrd_v_i,
    input  logic [OUTPUT_PORT_NUM*VC_ID_NUM_MAX_W-1:0]  tx_lcrd_id_i,
    output logic                                        crd_err_o
);

    localparam int VW     = VC_ID_NUM_MAX_W;
    localparam int VC_NUM = 1 << VW;

    logic [CRD_W-1:0]            crd [OUTPUT_PORT_NUM][VC_NUM];
    logic [IP_W-1:0]             ptr [OUTPUT_PORT_NUM];
    logic                        crd_err_q;

    logic [OUTPUT_PORT_NUM-1:0]  out_gnt;
    logic [IP_W-1:0]             out_src [OUTPUT_PORT_NUM];
    logic [VW-1:0]               out_vc  [OUTPUT_PORT_NUM];
    logic [INPUT_PORT_NUM-1:0]   in_gnt;
    logic                        bad_port;
    logic [VC_NUM-1:0]           crd_inc [OUTPUT_PORT_NUM];
    logic [VC_NUM-1:0]           crd_dec [OUTPUT_PORT_NUM];

    // Arbitration: scan inputs starting at ptr[o]; the first eligible one wins.
    always_comb begin
        int idx;
        out_gnt  = '0;
        in_gnt   = '0;
        bad_port = 1'b0;
        idx      = 0;
        for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
            out_src[o] = '0;
            out_vc[o]  = '0;
        end
        for (int i = 0; i < INPUT_PORT_NUM; i++) begin
            if (sa_req_v_i[i] && (int'(sa_req_outport_i[i*OP_W +: OP_W]) >= OUTPUT_PORT_NUM)) begin
                bad_port = 1'b1;
            end
        end
        for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
            for (int k = 0; k < INPUT_PORT_NUM; k++) begin
                idx = int'(ptr[o]) + k;
                if (idx >= INPUT_PORT_NUM) begin
                    idx = idx - INPUT_PORT_NUM;
                end
                if (!out_gnt[o] && sa_req_v_i[idx]
                    && (int'(sa_req_outport_i[idx*OP_W +: OP_W]) == o)
                    && (crd[o][sa_req_vc_id_i[idx*VW +: VW]] != '0)) begin
                    out_gnt[o]  = 1'b1;
                    out_src[o]  = IP_W'(idx);
                    out_vc[o]   = sa_req_vc_id_i[idx*VW +: VW];
                    in_gnt[idx] = 1'b1;
                end
            end
        end
    end

    // Per (output, VC) credit consume/return strobes.
    always_comb begin
        for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
            crd_inc[o] = '0;
            crd_dec[o] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                crd_inc[o][v] = tx_lcrd_v_i[o] && (tx_lcrd_id_i[o*VW +: VW] == VW'(v));
                crd_dec[o][v] = out_gnt[o] && (out_vc[o] == VW'(v));
            end
        end
    end

    // Grant outputs are forced to zero while reset is asserted.
    always_comb begin
        inport_read_enable_sa_stage = '0;
        inport_read_vc_id_sa_stage  = '0;
        xbar_v_o                    = '0;
        xbar_sel_o                  = '0;
        if (rstn) begin
            inport_read_enable_sa_stage = in_gnt;
            for (int i = 0; i < INPUT_PORT_NUM; i++) begin
                if (in_gnt[i]) begin
                    inport_read_vc_id_sa_stage[i*VW +: VW] = sa_req_vc_id_i[i*VW +: VW];
                end
            end
            xbar_v_o = out_gnt;
            for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
                if (out_gnt[o]) begin
                    xbar_sel_o[o*IP_W +: IP_W] = out_src[o];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
                ptr[o] <= '0;
                for (int v = 0; v < VC_NUM; v++) begin
                    crd[o][v] <= CRD_W'(CRD_MAX);
                end
            end
            crd_err_q <= 1'b0;
        end else begin
            for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
                if (out_gnt[o]) begin
                    ptr[o] <= (out_src[o] == IP_W'(INPUT_PORT_NUM - 1)) ? '0 : out_src[o] + 1'b1;
                end
                for (int v = 0; v < VC_NUM; v++) begin
                    // Grant and return on the same (o,v) cancel; a lone return at full saturates.
                    if (crd_inc[o][v] && !crd_dec[o][v]) begin
                        if (crd[o][v] == CRD_W'(CRD_MAX)) begin
                            crd_err_q <= 1'b1;
                        end else begin
                            crd[o][v] <= crd[o][v] + 1'b1;
                        end
                    end else if (crd_dec[o][v] && !crd_inc[o][v]) begin
                        crd[o][v] <= crd[o][v] - 1'b1;
                    end
                end
            end
            if (bad_port) begin
                crd_err_q <= 1'b1;
            end
        end
    end

    assign crd_err_o = crd_err_q;

endmodule
